psram_word_adapter: RTL
=======================

# psram_word_adapter

Converts 32-bit word requests from the bridge/core side into the pair of 16-bit halfword accesses that the PSRAM controller executes, then reassembles read data into a 32-bit response. It sits directly upstream of the PSRAM controller and drives its `write_en`/`read_en`/`addr`/`data_in`/`bank_sel` command port. It holds up to two pending requests so the requester is not stalled for a full access. It sequences each halfword around the controller's `busy`/`read_avail` handshake.

## Interface
Parameters:
- FIFO_DEPTH, 2: pending-request entries; must be a power of two, ≥2.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, shared with the PSRAM controller
- reset  in  1  synchronous, active-high
- req_valid  in  1  request offered
- req_ready  out  1  space in the request FIFO (not full)
- req_write  in  1  1 = write, 0 = read
- req_addr  in  22  32-bit word address; bit 21 = bank, [20:0] = word index
- req_wdata  in  32  write data; [15:0] goes to even halfword
- rsp_valid  out  1  one-cycle pulse, read data ready
- rsp_rdata  out  32  assembled read data, held until next rsp_valid
- psram_bank_sel  out  1  bank select to controller
- psram_addr  out  22  halfword address {word_index, half}
- psram_write_en  out  1  one-cycle write command
- psram_data_in  out  16  halfword write data
- psram_read_en  out  1  one-cycle read command
- psram_read_avail  in  1  controller read-data strobe
- psram_data_out  in  16  controller read data
- psram_busy  in  1  controller busy

## Operation
- Handshake: a request is accepted on a cycle with req_valid && req_ready. It is pushed into the FIFO as {write, addr, wdata}. req_ready = !full.
- States: IDLE, ISSUE_LO, WAIT_LO, ISSUE_HI, WAIT_HI, RESP.
- IDLE: the FIFO head is popped when the FIFO is non-empty and psram_busy==0, then go to ISSUE_LO. The head is latched into a working register.
- ISSUE_LO/ISSUE_HI: assert exactly one of psram_write_en/psram_read_en for exactly one cycle. psram_addr = {addr[20:0], 0|1}, psram_bank_sel = addr[21], psram_data_in = wdata[15:0] or wdata[31:16].
- WAIT_x: the first cycle is blind (busy is ignored, because the controller asserts busy one cycle after sampling the enable). After that, exit when psram_busy==0.
  - For reads, capture psram_data_out into the low or high half on the cycle psram_read_avail==1.
  - WAIT_LO → ISSUE_HI.
  - WAIT_HI → RESP for reads, IDLE for writes.
- RESP: rsp_valid=1 for one cycle with rsp_rdata = {hi, lo}, then IDLE.
- Command outputs (addr, bank_sel, data_in) are registered and stable from the enable cycle until the next ISSUE.
- Requests complete strictly in acceptance order. Reads and writes never overlap.
- A simultaneous push and pop in the same cycle is legal at any occupancy, including full: pop frees a slot, but req_ready still reflects the registered full flag.

## Timing
- Reset values:
  - req_ready=1, rsp_valid=0, rsp_rdata=0
  - psram_write_en=0, psram_read_en=0, psram_addr=0, psram_bank_sel=0, psram_data_in=0
  - state=IDLE, FIFO empty
- Reset mid-operation: enables drop on the next cycle and the FIFO is flushed. No rsp_valid is issued for the aborted request. The controller is not reset, so IDLE waits for psram_busy==0 before issuing anything.
- Adapter overhead per halfword:
  - 1 issue cycle
  - 1 blind cycle
  - the cycle busy is seen low
- Write latency from pop: 2×(controller write cycles) + 4.
- Read rsp_valid: 1 cycle after the WAIT_HI exit.
- If psram_read_avail does not arrive before busy falls, the half reads as the last captured value. The bench flags this as an error.

## Structure
- Package psram_adapter_pkg: state enum, request struct {write, addr[21:0], wdata[31:0]}, and constant HALF_LO/HALF_HI.
- Sub-module psram_req_fifo: synchronous FIFO parameterised by width and depth, with full/empty registered and sync reset.

## Test plan
- Write: req addr=0x000010, wdata=0xDEADBEEF → psram writes halfword addr 0x000020=0xBEEF, then 0x000021=0xDEAD, bank_sel=0, one enable pulse each.
- Read back 0x000010 with the controller model returning 0xBEEF/0xDEAD → one rsp_valid, rsp_rdata=0xDEADBEEF.
- Bank 1: req addr=0x200003 → psram_bank_sel=1, psram_addr=0x000006 then 0x000007.
- Back-to-back: 3 requests on consecutive cycles → req_ready drops after 2 pending, third accepted after first pop. Order is preserved and no enable is issued while busy=1.
- Reset asserted during WAIT_HI of a read → no rsp_valid, FIFO empty, next request not issued until psram_busy==0.
- Push and pop same cycle with the FIFO full → occupancy unchanged, no data lost or duplicated.

Source files
------------

// File: rtl/psram_adapter_pkg.sv
// Shared types for the 32-bit word to 16-bit halfword PSRAM adapter.
package psram_adapter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE_LO,
    ST_WAIT_LO,
    ST_ISSUE_HI,
    ST_WAIT_HI,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic        write;
    logic [21:0] addr;
    logic [31:0] wdata;
  } req_t;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;
  localparam int   REQ_W   = $bits(req_t);

endpackage

// File: rtl/psram_req_fifo.sv
// Synchronous FIFO with registered full/empty flags and synchronous active-high reset.
module psram_req_fifo #(
  parameter int WIDTH = 55,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_full;
  logic             r_empty;
  logic             w_do_push;
  logic             w_do_pop;
  logic [AW:0]      w_count_nxt;

  // A pop frees the slot a same-cycle push lands in, so push is legal when full.
  assign w_do_pop  = pop && !r_empty;
  assign w_do_push = push && (!r_full || w_do_pop);

  always_comb begin
    w_count_nxt = r_count;
    if (w_do_push && !w_do_pop)      w_count_nxt = r_count + 1'b1;
    else if (!w_do_push && w_do_pop) w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_CNT);
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

  assign rdata = r_mem[r_rd_ptr];
  assign full  = r_full;
  assign empty = r_empty;

endmodule

// File: rtl/psram_word_adapter.sv
// Splits 32-bit word requests into two PSRAM halfword commands and reassembles reads.
// IDLE: pop head when controller idle | ISSUE_x: one enable pulse | WAIT_x: blind cycle, then wait busy low | RESP: rsp pulse
module psram_word_adapter
  import psram_adapter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [21:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        psram_bank_sel,
  output logic [21:0] psram_addr,
  output logic        psram_write_en,
  output logic [15:0] psram_data_in,
  output logic        psram_read_en,
  input  logic        psram_read_avail,
  input  logic [15:0] psram_data_out,
  input  logic        psram_busy
);

  state_t           r_state;
  state_t           w_state_nxt;
  req_t             r_work;
  req_t             w_head;
  req_t             w_cur;
  logic [REQ_W-1:0] w_fifo_rdata;
  logic [REQ_W-1:0] w_push_data;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             r_blind;
  logic             w_issue;
  logic             w_half;

  logic        r_write_en,  w_write_en_nxt;
  logic        r_read_en,   w_read_en_nxt;
  logic [21:0] r_addr,      w_addr_nxt;
  logic        r_bank,      w_bank_nxt;
  logic [15:0] r_data_in,   w_data_in_nxt;
  logic [15:0] r_lo,        w_lo_nxt;
  logic [15:0] r_hi,        w_hi_nxt;
  logic        r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0] r_rsp_rdata, w_rsp_rdata_nxt;

  assign w_push      = req_valid && !w_full;
  assign w_push_data = {req_write, req_addr, req_wdata};
  assign w_head      = req_t'(w_fifo_rdata);
  assign w_pop       = (r_state == ST_IDLE) && !w_empty && !psram_busy;

  psram_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .wdata (w_push_data),
    .pop   (w_pop),
    .rdata (w_fifo_rdata),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_work  <= '0;
      r_blind <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) r_work <= w_head;
      r_blind <= (r_state == ST_ISSUE_LO) || (r_state == ST_ISSUE_HI);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (w_pop) w_state_nxt = ST_ISSUE_LO;
      ST_ISSUE_LO: w_state_nxt = ST_WAIT_LO;
      ST_WAIT_LO:  if (!r_blind && !psram_busy) w_state_nxt = ST_ISSUE_HI;
      ST_ISSUE_HI: w_state_nxt = ST_WAIT_HI;
      ST_WAIT_HI:  if (!r_blind && !psram_busy) w_state_nxt = r_work.write ? ST_IDLE : ST_RESP;
      ST_RESP:     w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state and registered, so they line up with the state.
  always_comb begin
    w_cur           = (r_state == ST_IDLE) ? w_head : r_work;
    w_issue         = (w_state_nxt == ST_ISSUE_LO) || (w_state_nxt == ST_ISSUE_HI);
    w_half          = (w_state_nxt == ST_ISSUE_HI) ? HALF_HI : HALF_LO;
    w_write_en_nxt  = 1'b0;
    w_read_en_nxt   = 1'b0;
    w_addr_nxt      = r_addr;
    w_bank_nxt      = r_bank;
    w_data_in_nxt   = r_data_in;
    w_lo_nxt        = r_lo;
    w_hi_nxt        = r_hi;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rdata_nxt = r_rsp_rdata;
    if (w_issue) begin
      w_write_en_nxt = w_cur.write;
      w_read_en_nxt  = !w_cur.write;
      w_addr_nxt     = {w_cur.addr[20:0], w_half};
      w_bank_nxt     = w_cur.addr[21];
      w_data_in_nxt  = (w_half == HALF_HI) ? w_cur.wdata[31:16] : w_cur.wdata[15:0];
    end
    if (psram_read_avail && !r_work.write) begin
      if (r_state == ST_WAIT_LO) w_lo_nxt = psram_data_out;
      if (r_state == ST_WAIT_HI) w_hi_nxt = psram_data_out;
    end
    if (w_state_nxt == ST_RESP) begin
      w_rsp_valid_nxt = 1'b1;
      w_rsp_rdata_nxt = {w_hi_nxt, w_lo_nxt};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_write_en  <= 1'b0;
      r_read_en   <= 1'b0;
      r_addr      <= '0;
      r_bank      <= 1'b0;
      r_data_in   <= '0;
      r_lo        <= '0;
      r_hi        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_write_en  <= w_write_en_nxt;
      r_read_en   <= w_read_en_nxt;
      r_addr      <= w_addr_nxt;
      r_bank      <= w_bank_nxt;
      r_data_in   <= w_data_in_nxt;
      r_lo        <= w_lo_nxt;
      r_hi        <= w_hi_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
    end
  end

  assign req_ready      = !w_full;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_rdata      = r_rsp_rdata;
  assign psram_write_en = r_write_en;
  assign psram_read_en  = r_read_en;
  assign psram_addr     = r_addr;
  assign psram_bank_sel = r_bank;
  assign psram_data_in  = r_data_in;

endmodule
